// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the packet sources, the arbiter and the UART_tx byte transmitter.
// The arbiter takes the slave modport; the source/transmitter side takes master.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_SRC = 2
);
  logic [NUM_SRC-1:0]    req;
  logic [32*NUM_SRC-1:0] pkt_data;
  logic [NUM_SRC-1:0]    ack;
  logic                  tx_trmt;
  logic [7:0]            tx_data;
  logic                  tx_done;
  logic                  busy;
  logic [3:0]            grant_id;

  modport master (
    output req, pkt_data, tx_done,
    input  ack, tx_trmt, tx_data, busy, grant_id
  );

  modport slave (
    input  req, pkt_data, tx_done,
    output ack, tx_trmt, tx_data, busy, grant_id
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART_tx between NUM_SRC sources; each grant sends a header byte
// {HDR_TAG, id} and 4 data bytes LSB first. Define CHECKSUM_EN to append an XOR checksum byte.
module uart_tx_arbiter #(
  parameter int unsigned NUM_SRC = 2,
  parameter logic [3:0]  HDR_TAG = 4'hA
) (
  input logic              clk,
  input logic              rst_n,
  uart_tx_arbiter_if.slave bus_io
);

  localparam int unsigned IdxW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
`ifdef CHECKSUM_EN
  localparam logic [2:0] LastCnt = 3'd5;
`else
  localparam logic [2:0] LastCnt = 3'd4;
`endif

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e      state_q, state_d;
  logic [3:0]  rr_q, rr_d;
  logic [3:0]  grant_q, grant_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] cap_q, cap_d;

  logic [3:0]  pick;
  logic        pick_vld;
  logic [31:0] pick_word;
  logic [7:0]  byte_sel;

  // Scan rr+1, rr+2, ... so the last granted source has lowest priority.
  always_comb begin
    int unsigned idx;
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned off = 1; off <= NUM_SRC; off++) begin
      idx = (32'(rr_q) + off) % NUM_SRC;
      if (!pick_vld && bus_io.req[IdxW'(idx)]) begin
        pick_vld = 1'b1;
        pick     = 4'(idx);
      end
    end
    pick_word = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (pick == 4'(i)) pick_word = bus_io.pkt_data[32*i +: 32];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rr_q    <= 4'(NUM_SRC - 1);
      grant_q <= '0;
      cnt_q   <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          cap_d   = pick_word;
          rr_d    = pick;
          grant_d = pick;
          cnt_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (bus_io.tx_done) begin
          if (cnt_q == LastCnt) begin
            state_d = StIdle;
          end else begin
            cnt_d   = cnt_q + 3'd1;
            state_d = StIssue;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    case (cnt_q)
      3'd0:    byte_sel = {HDR_TAG, grant_q};
      3'd1:    byte_sel = cap_q[7:0];
      3'd2:    byte_sel = cap_q[15:8];
      3'd3:    byte_sel = cap_q[23:16];
      3'd4:    byte_sel = cap_q[31:24];
`ifdef CHECKSUM_EN
      3'd5:    byte_sel = {HDR_TAG, grant_q} ^ cap_q[7:0] ^ cap_q[15:8] ^ cap_q[23:16] ^
                          cap_q[31:24];
`endif
      default: byte_sel = '0;
    endcase
  end

  always_comb begin
    bus_io.ack      = '0;
    bus_io.tx_trmt  = 1'b0;
    bus_io.tx_data  = '0;
    bus_io.busy     = (state_q != StIdle);
    bus_io.grant_id = grant_q;
    if (state_q == StIssue) begin
      bus_io.tx_trmt = 1'b1;
      bus_io.tx_data = byte_sel;
      if (cnt_q == 3'd0) bus_io.ack = NUM_SRC'(1) << grant_q;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with NUM_SRC=2; expected packet bytes come from a
// small byte-order model. Honours CHECKSUM_EN for the optional sixth byte.
module tb_uart_tx_arbiter;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   ack1_seen = 0;

  localparam logic [31:0] Word0 = 32'h44332211;
  localparam logic [31:0] Word1 = 32'hDDCCBBAA;
`ifdef CHECKSUM_EN
  localparam int NBytes = 6;
`else
  localparam int NBytes = 5;
`endif

  uart_tx_arbiter_if #(.NUM_SRC(2)) bus ();

  uart_tx_arbiter #(
    .NUM_SRC(2),
    .HDR_TAG(4'hA)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.ack[1]) ack1_seen++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pkt_byte(input int g, input logic [31:0] w, input int i);
    logic [7:0] b [6];
    b[0] = {4'hA, 4'(g)};
    b[1] = w[7:0];
    b[2] = w[15:8];
    b[3] = w[23:16];
    b[4] = w[31:24];
    b[5] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4];
    return b[i];
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ack"}, 32'(bus.ack), 32'd0);
    chk({tag, "_trmt"}, 32'(bus.tx_trmt), 32'd0);
    chk({tag, "_data"}, 32'(bus.tx_data), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_gid"}, 32'(bus.grant_id), 32'd0);
  endtask

  // Entered one cycle after the capture edge (header in ISSUE); leaves in IDLE.
  task automatic run_packet(input string tag, input int g, input logic [31:0] w,
                            input bit drop, input int stall_idx, input int glitch_idx);
    int trmt_seen;
    for (int i = 0; i < NBytes; i++) begin
      chk($sformatf("%s_trmt%0d", tag, i), 32'(bus.tx_trmt), 32'd1);
      chk($sformatf("%s_byte%0d", tag, i), 32'(bus.tx_data), 32'(pkt_byte(g, w, i)));
      chk($sformatf("%s_ack%0d", tag, i), 32'(bus.ack), (i == 0) ? (32'd1 << g) : 32'd0);
      chk($sformatf("%s_busy%0d", tag, i), 32'(bus.busy), 32'd1);
      if (i == 0) begin
        chk({tag, "_gid"}, 32'(bus.grant_id), 32'(g));
        if (drop) bus.req[g] = 1'b0;
      end
      step();
      chk($sformatf("%s_wait%0d", tag, i), 32'(bus.tx_trmt), 32'd0);
      if (i == glitch_idx) begin
        bus.req[1] = 1'b1;
        step();
        bus.req[1] = 1'b0;
      end
      if (i == stall_idx) begin
        trmt_seen = 0;
        repeat (1000) begin
          step();
          if (bus.tx_trmt) trmt_seen++;
        end
        chk({tag, "_stall_trmt"}, 32'(trmt_seen), 32'd0);
        chk({tag, "_stall_busy"}, 32'(bus.busy), 32'd1);
      end
      bus.tx_done = 1'b1;
      step();
      bus.tx_done = 1'b0;
    end
    chk({tag, "_end_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_end_trmt"}, 32'(bus.tx_trmt), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int ack1_before;
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.pkt_data = {Word1, Word0};
    bus.tx_done  = 1'b0;
    step();
    chk_idle_outputs("reset");
    do_reset();

    // Single request from source 0.
    bus.req = 2'b01;
    step();
    run_packet("single", 0, Word0, 1'b1, -1, -1);

    // Both sources held: grants alternate, IDLE lasts one cycle between packets.
    do_reset();
    bus.req = 2'b11;
    step();
    run_packet("rr0", 0, Word0, 1'b0, -1, -1);
    step();
    run_packet("rr1", 1, Word1, 1'b0, -1, -1);
    step();
    run_packet("rr2", 0, Word0, 1'b0, -1, -1);
    step();
    run_packet("rr3", 1, Word1, 1'b0, -1, -1);
    bus.req = 2'b00;
    step();
    chk("rr_idle_busy", 32'(bus.busy), 32'd0);

    // Long tx_done stall after byte2.
    bus.req = 2'b01;
    step();
    run_packet("stall", 0, Word0, 1'b1, 2, -1);

    // One-cycle glitch on req[1] while busy is never served.
    ack1_before = ack1_seen;
    bus.req = 2'b01;
    step();
    run_packet("glitch", 0, Word0, 1'b1, -1, 1);
    repeat (3) step();
    chk("glitch_trmt", 32'(bus.tx_trmt), 32'd0);
    chk("glitch_busy", 32'(bus.busy), 32'd0);
    chk("glitch_ack1", 32'(ack1_seen - ack1_before), 32'd0);

    // Reset mid-packet after byte2 is issued.
    bus.req = 2'b01;
    step();
    bus.req = 2'b00;
    step();
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    step();
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    chk("abort_pre_data", 32'(bus.tx_data), 32'(pkt_byte(0, Word0, 2)));
    step();
    rst_n = 1'b0;
    #2;
    chk_idle_outputs("abort");
    step();
    rst_n = 1'b1;
    bus.req = 2'b10;
    step();
    run_packet("after_rst", 1, Word1, 1'b1, -1, -1);

    // Spurious tx_done while idle.
    bus.tx_done = 1'b1;
    step();
    chk("spur_trmt", 32'(bus.tx_trmt), 32'd0);
    chk("spur_busy", 32'(bus.busy), 32'd0);
    bus.tx_done = 1'b0;
    step();
    chk("spur_trmt2", 32'(bus.tx_trmt), 32'd0);
    chk("spur_gid_hold", 32'(bus.grant_id), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
